instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 16-bit CPU, directly upstream of the instruction memory. It owns the program counter and drives it to the byte-addressed instruction memory, which returns a 16-bit instruction combinationally as {byte[PC], byte[PC+1]}. The fetched word is captured in an IF/ID instruction register (IR) with its PC and a valid flag. The block also handles stall, taken-branch redirect with wrong-path flush, and a HALT opcode that stops fetching.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- MEM_BYTES, 128, instruction memory size in bytes; power of two, ≥ 4.
- HALT_OPCODE, 4'hF, value of Instruction[15:12] that halts fetch.

- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; forces reset state immediately.
- PC  output  16  fetch address to the instruction memory; registered.
- Instruction  input  16  word returned by the instruction memory for the current PC, same cycle.
- Stall  input  1  hazard from decode/execute; freezes the fetch stage.
- BranchTaken  input  1  redirect request from execute; single-cycle pulse.
- BranchTarget  input  16  redirect byte address; valid when BranchTaken=1.
- IR  output  16  latched instruction.
- IRPC  output  16  address IR was fetched from.
- IRValid  output  1  IR holds a real instruction, not a bubble.
- Halted  output  1  fetch is stopped by HALT.

## Operation
- Two states: RUN and HALTED. Reset state is RUN.
- Reset values: PC=RESET_PC, IR=16'h0000, IRPC=16'h0000, IRValid=0, Halted=0.
- Address rule: every PC load is masked to the range 0..MEM_BYTES-1 and has bit 0 forced to 0: next PC = value & (MEM_BYTES-2).
- Priority per edge: BranchTaken > Stall > state action.
- BranchTaken=1 in any state, including during Stall:
  - PC ← masked BranchTarget.
  - IRValid ← 0; IR ← 0 (flushes the wrong-path instruction).
  - State ← RUN; Halted ← 0.
- Stall=1 with BranchTaken=0: PC, IR, IRPC, IRValid and state all hold.
- RUN with no stall or branch:
  - IR ← Instruction; IRPC ← PC; IRValid ← 1.
  - If Instruction[15:12] ≠ HALT_OPCODE: PC ← (PC+2) masked. Wraps from MEM_BYTES-2 to 0.
  - If Instruction[15:12] = HALT_OPCODE: PC holds; state ← HALTED; Halted ← 1.
- HALTED with no stall or branch:
  - PC holds; IRValid ← 0. The HALT is presented exactly once.
  - IR and IRPC hold.
  - Stays HALTED until BranchTaken or Reset.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. Fetch resumes at RESET_PC on the first edge after deassertion.

## Timing
- PC is a register output. Instruction must settle within the same cycle; there is no internal path from Instruction to PC other than the halt decode.
- Fetch latency is 1 cycle: the word at PC appears in IR after the next rising edge.
- Throughput is one instruction per cycle while in RUN without stall.
- Branch penalty is 1 bubble.
  - BranchTaken sampled at edge k gives PC=target and IRValid=0 after edge k.
  - At edge k+1, IR holds the word at the target and IRValid=1, unless Stall is asserted.
- Halted rises at the same edge that latches the HALT word into IR. IRValid falls one edge later.
- The Stall and BranchTaken inputs are sampled only at rising edges; there is no combinational path from them to any output.

## Test plan
- Reset/sequential fetch:
  - Stimulus: memory 0..5 = 1234 5678 9ABC; release Reset.
  - Required: PC=0 at reset. After edges 1, 2, 3: IR=1234/5678/9ABC, IRPC=0/2/4, IRValid=1, PC=2/4/6.
- Wrap-around:
  - Stimulus: branch to 126 (word 0x0101), then word at 0 = 0x2222.
  - Required: IR=0101 with IRPC=126, then PC=0, then IR=2222 with IRPC=0.
- Stall:
  - Stimulus: Stall high for 3 cycles at PC=4.
  - Required: PC=4, IR and IRPC unchanged, IRValid unchanged throughout; on release the next edge latches the word at 4.
- Branch redirect:
  - Stimulus: BranchTaken=1 with BranchTarget=0x0011 while Stall=1.
  - Required: PC=0x0010, IRValid=0 after that edge; IR=word at 0x10 with IRValid=1 one edge later.
- Halt:
  - Stimulus: word 0xF000 at address 6.
  - Required: IR=F000 and Halted=1 at the same edge, PC stays 6, IRValid=0 one edge later and remains 0.
  - Follow-up: BranchTaken to 0 gives Halted=0 and fetch resumes at 0.
- Async reset mid-run:
  - Stimulus: assert Reset between edges at PC=0x0A.
  - Required: PC=0, IR=0, IRValid=0, Halted=0 immediately, before any clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID instruction register, stall, branch redirect, halt
module instruction_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_BYTES   = 128,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] PC,
  input  logic [15:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic [15:0] IR,
  output logic [15:0] IRPC,
  output logic        IRValid,
  output logic        Halted
);

  // Keeps every PC load inside memory and halfword aligned.
  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 2);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] irpc_q, irpc_d;
  logic        ir_valid_q, ir_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    irpc_d     = irpc_q;
    ir_valid_d = ir_valid_q;
    if (BranchTaken) begin
      pc_d       = BranchTarget & ADDR_MASK;
      ir_d       = 16'h0000;
      ir_valid_d = 1'b0;
      state_d    = RUN;
    end else if (!Stall) begin
      case (state_q)
        RUN: begin
          ir_d       = Instruction;
          irpc_d     = pc_q;
          ir_valid_d = 1'b1;
          if (Instruction[15:12] == HALT_OPCODE) begin
            state_d = HALTED;
          end else begin
            pc_d = (pc_q + 16'd2) & ADDR_MASK;
          end
        end
        HALTED: begin
          // The HALT word stays in IR but is presented as valid only once.
          ir_valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      irpc_q     <= 16'h0000;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      irpc_q     <= irpc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign PC      = pc_q;
  assign IR      = ir_q;
  assign IRPC    = irpc_q;
  assign IRValid = ir_valid_q;
  assign Halted  = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed plus randomized checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;

  localparam int MEM_BYTES = 128;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic [15:0] IR;
  logic [15:0] IRPC;
  logic        IRValid;
  logic        Halted;

  logic [7:0] mem [MEM_BYTES];

  int total = 0;
  int bad   = 0;

  int m_pc, m_ir, m_irpc, m_valid, m_halted;

  instruction_fetch #(
    .RESET_PC   (16'h0000),
    .MEM_BYTES  (MEM_BYTES),
    .HALT_OPCODE(4'hF)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .PC          (PC),
    .Instruction (Instruction),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .IR          (IR),
    .IRPC        (IRPC),
    .IRValid     (IRValid),
    .Halted      (Halted)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    Instruction = {mem[int'(PC) % MEM_BYTES], mem[(int'(PC) + 1) % MEM_BYTES]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int mem_word(input int addr);
    return mem[addr] * 256 + mem[addr + 1];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0; m_halted = 0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [15:0] t);
    int word;
    word = mem_word(m_pc);
    if (b) begin
      m_pc = ((int'(t) % MEM_BYTES) / 2) * 2;
      m_ir = 0; m_valid = 0; m_halted = 0;
    end else if (s) begin
      // everything holds
    end else if (m_halted == 0) begin
      m_ir = word; m_irpc = m_pc; m_valid = 1;
      if (word / 4096 == 15) m_halted = 1;
      else m_pc = (m_pc + 2) % MEM_BYTES;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".pc"},     PC,                16'(m_pc));
    chk({tag, ".ir"},     IR,                16'(m_ir));
    chk({tag, ".irpc"},   IRPC,              16'(m_irpc));
    chk({tag, ".valid"},  {15'b0, IRValid},  16'(m_valid));
    chk({tag, ".halted"}, {15'b0, Halted},   16'(m_halted));
  endtask

  task automatic cycle(input string tag, input logic s, input logic b, input logic [15:0] t);
    Stall = s; BranchTaken = b; BranchTarget = t;
    model_step(s, b, t);
    @(posedge Clock);
    #1;
    model_check(tag);
  endtask

  task automatic set_word(input int addr, input logic [15:0] w);
    mem[addr]     = w[15:8];
    mem[addr + 1] = w[7:0];
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    set_word(0, 16'h1234);
    set_word(2, 16'h5678);
    set_word(4, 16'h9ABC);
    set_word(6, 16'hF000);
    model_reset();
    #12;
    chk("rst.pc", PC, 16'h0000);
    chk("rst.ir", IR, 16'h0000);
    chk("rst.irpc", IRPC, 16'h0000);
    chk("rst.valid", {15'b0, IRValid}, 16'h0000);
    chk("rst.halted", {15'b0, Halted}, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;

    cycle("seq1", 1'b0, 1'b0, 16'h0);
    chk("seq1.ir", IR, 16'h1234); chk("seq1.pc", PC, 16'h0002);
    cycle("seq2", 1'b0, 1'b0, 16'h0);
    chk("seq2.ir", IR, 16'h5678); chk("seq2.irpc", IRPC, 16'h0002);

    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b1, 1'b0, 16'h0);
      chk("stall.pc", PC, 16'h0004); chk("stall.ir", IR, 16'h5678);
      chk("stall.valid", {15'b0, IRValid}, 16'h0001);
    end
    cycle("seq3", 1'b0, 1'b0, 16'h0);
    chk("seq3.ir", IR, 16'h9ABC); chk("seq3.irpc", IRPC, 16'h0004); chk("seq3.pc", PC, 16'h0006);

    cycle("halt1", 1'b0, 1'b0, 16'h0);
    chk("halt1.ir", IR, 16'hF000); chk("halt1.halted", {15'b0, Halted}, 16'h0001);
    chk("halt1.pc", PC, 16'h0006);
    cycle("halt2", 1'b0, 1'b0, 16'h0);
    chk("halt2.valid", {15'b0, IRValid}, 16'h0000); chk("halt2.pc", PC, 16'h0006);
    cycle("halt3", 1'b0, 1'b0, 16'h0);
    chk("halt3.valid", {15'b0, IRValid}, 16'h0000);
    cycle("unhalt", 1'b0, 1'b1, 16'h0000);
    chk("unhalt.halted", {15'b0, Halted}, 16'h0000); chk("unhalt.pc", PC, 16'h0000);
    cycle("resume", 1'b0, 1'b0, 16'h0);
    chk("resume.ir", IR, 16'h1234); chk("resume.irpc", IRPC, 16'h0000);

    cycle("br", 1'b1, 1'b1, 16'h0011);
    chk("br.pc", PC, 16'h0010); chk("br.valid", {15'b0, IRValid}, 16'h0000);
    cycle("br2", 1'b0, 1'b0, 16'h0);
    chk("br2.ir", IR, 16'(mem_word(16))); chk("br2.valid", {15'b0, IRValid}, 16'h0001);

    set_word(126, 16'h0101);
    cycle("wrap0", 1'b0, 1'b1, 16'd126);
    chk("wrap0.pc", PC, 16'd126);
    cycle("wrap1", 1'b0, 1'b0, 16'h0);
    chk("wrap1.ir", IR, 16'h0101); chk("wrap1.irpc", IRPC, 16'd126); chk("wrap1.pc", PC, 16'h0000);
    set_word(0, 16'h2222);
    cycle("wrap2", 1'b0, 1'b0, 16'h0);
    chk("wrap2.ir", IR, 16'h2222); chk("wrap2.irpc", IRPC, 16'h0000);

    cycle("to0a", 1'b0, 1'b1, 16'h000A);
    chk("to0a.pc", PC, 16'h000A);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("arst.pc", PC, 16'h0000);
    chk("arst.ir", IR, 16'h0000);
    chk("arst.valid", {15'b0, IRValid}, 16'h0000);
    chk("arst.halted", {15'b0, Halted}, 16'h0000);
    #1 Reset = 1'b0;
    cycle("post_rst", 1'b0, 1'b0, 16'h0);
    chk("post_rst.ir", IR, 16'h2222); chk("post_rst.pc", PC, 16'h0002);

    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom % 4) == 0, ($urandom % 8) == 0, 16'($urandom));
    end
    Stall = 1'b0; BranchTaken = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
